// File: rtl/mxint8_quantize.sv
// MXINT8 block producer: gathers BLOCK_SIZE signed fixed-point samples, derives the shared
// E8M0 scale from the largest magnitude, then converts one element per cycle into 1.6 int8.
module mxint8_quantize #(
  parameter int BLOCK_SIZE  = 32,
  parameter int IN_WIDTH    = 16,
  parameter int FRAC_BITS   = 8,
  parameter int SCALE_WIDTH = 8,
  parameter int ELEM_WIDTH  = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [IN_WIDTH-1:0]              i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [SCALE_WIDTH-1:0]           o_scale,
  output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_mxint8_elements,
  output logic                             o_saturated
);

  localparam int CW   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int MW   = IN_WIDTH + 1;
  localparam int PW   = $clog2(MW + 1);
  localparam int TGT  = ELEM_WIDTH - 2;
  localparam int WW   = IN_WIDTH + ELEM_WIDTH + 2;
  localparam int EMAX = (2 ** (ELEM_WIDTH - 1)) - 1;
  localparam logic signed [WW-1:0] EMAX_W = WW'(EMAX);
  localparam logic signed [WW-1:0] EMIN_W = -WW'(EMAX);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CONVERT = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  count_q;
  logic [MW-1:0]                  maxabs_q;
  logic [PW-1:0]                  p_q;
  logic [SCALE_WIDTH-1:0]         scale_q;
  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elems_q;
  logic                           sat_q;
  logic [IN_WIDTH-1:0]            buf_q [BLOCK_SIZE];

  logic                           in_fire;
  logic                           out_fire;
  logic                           count_last;
  logic [MW-1:0]                  in_ext;
  logic [MW-1:0]                  abs_in;
  logic [MW-1:0]                  maxabs_new;
  logic [PW-1:0]                  p_new;
  int                             scale_int;
  logic [SCALE_WIDTH-1:0]         scale_new;

  logic [IN_WIDTH-1:0]            cur;
  logic signed [WW-1:0]           cur_ext;
  logic [WW-1:0]                  cur_mag;
  logic [WW-1:0]                  rnd;
  int                             rsh;
  logic signed [WW-1:0]           conv;
  logic [ELEM_WIDTH-1:0]          elem_d;
  logic                           clamp_hit;

  assign in_fire    = i_valid & o_ready;
  assign out_fire   = o_valid & i_ready;
  assign count_last = (count_q == CW'(BLOCK_SIZE - 1));

  // Magnitude is one bit wider than the sample so the most negative input stays exact.
  assign in_ext     = {i_data[IN_WIDTH-1], i_data};
  assign abs_in     = in_ext[MW-1] ? (~in_ext + MW'(1)) : in_ext;
  assign maxabs_new = (abs_in > maxabs_q) ? abs_in : maxabs_q;

  always_comb begin
    p_new = '0;
    for (int i = 0; i < MW; i++) begin
      if (maxabs_new[i]) p_new = PW'(i);
    end
  end

  always_comb begin
    scale_int = int'(p_new) - FRAC_BITS + 127;
    scale_new = '0;
    if (maxabs_new == '0)      scale_new = '0;
    else if (scale_int < 0)    scale_new = '0;
    else if (scale_int > 254)  scale_new = SCALE_WIDTH'(254);
    else                       scale_new = SCALE_WIDTH'(scale_int);
  end

  // Element k lands on the k-th edge of CONVERT, so the buffer is read in the same cycle.
  always_comb begin
    cur       = buf_q[count_q];
    cur_ext   = {{(WW-IN_WIDTH){cur[IN_WIDTH-1]}}, cur};
    cur_mag   = cur_ext[WW-1] ? (~cur_ext + WW'(1)) : cur_ext;
    rnd       = '0;
    rsh       = 0;
    conv      = '0;
    elem_d    = '0;
    clamp_hit = 1'b0;
    if (int'(p_q) <= TGT) begin
      conv = cur_ext <<< (TGT - int'(p_q));
    end else begin
      // Rounding the magnitude and reapplying the sign gives ties away from zero.
      rsh  = int'(p_q) - TGT;
      rnd  = (cur_mag + (WW'(1) << (rsh - 1))) >> rsh;
      conv = cur_ext[WW-1] ? -rnd : rnd;
    end
    if (conv > EMAX_W) begin
      elem_d    = ELEM_WIDTH'(EMAX_W);
      clamp_hit = 1'b1;
    end else if (conv < EMIN_W) begin
      elem_d    = ELEM_WIDTH'(EMIN_W);
      clamp_hit = 1'b1;
    end else begin
      elem_d    = ELEM_WIDTH'(conv);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_COLLECT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (in_fire && count_last) state_d = S_CONVERT;
      S_CONVERT: if (count_last)            state_d = S_OUTPUT;
      S_OUTPUT:  if (i_ready)               state_d = S_COLLECT;
      default:                              state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    o_ready = (state_q == S_COLLECT);
    o_valid = (state_q == S_OUTPUT);
  end

  // Sample storage carries no reset: contents are only read after being written.
  always_ff @(posedge i_clk) begin
    if (in_fire) buf_q[count_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      maxabs_q <= '0;
      p_q      <= '0;
      scale_q  <= '0;
      elems_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (in_fire) begin
            maxabs_q <= maxabs_new;
            if (count_last) begin
              count_q <= '0;
              p_q     <= p_new;
              scale_q <= scale_new;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        S_CONVERT: begin
          elems_q[int'(count_q)*ELEM_WIDTH +: ELEM_WIDTH] <= elem_d;
          sat_q   <= sat_q | clamp_hit;
          count_q <= count_last ? '0 : count_q + CW'(1);
        end
        S_OUTPUT: begin
          if (out_fire) begin
            maxabs_q <= '0;
            sat_q    <= 1'b0;
          end
        end
        default: begin
          count_q <= '0;
        end
      endcase
    end
  end

  assign o_scale           = scale_q;
  assign o_mxint8_elements = elems_q;
  assign o_saturated       = sat_q;

endmodule

// File: tb/tb_mxint8_quantize.sv
// Bench for mxint8_quantize: expected blocks come from a real-arithmetic model and are
// queued when samples are driven, then popped and compared when a block is presented.
module tb_mxint8_quantize;

  localparam int BS = 32;

  logic          clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [15:0]   i_data;
  logic          o_valid;
  logic          i_ready;
  logic [7:0]    o_scale;
  logic [255:0]  o_elems;
  logic          o_saturated;

  typedef struct {
    logic [7:0]   scale;
    logic [255:0] elems;
    logic         sat;
  } exp_t;

  exp_t          sb[$];
  logic [15:0]   stim [BS];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  mxint8_quantize dut (
    .i_clk             (clk),
    .i_rst_n           (i_rst_n),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_data            (i_data),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_scale           (o_scale),
    .o_mxint8_elements (o_elems),
    .o_saturated       (o_saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_expected();
    exp_t e;
    int   mx;
    int   p;
    int   s;
    int   iv;
    int   q;
    real  v;
    real  r;
    mx = 0;
    for (int i = 0; i < BS; i++) begin
      iv = int'($signed(stim[i]));
      if (iv < 0) iv = -iv;
      if (iv > mx) mx = iv;
    end
    e.scale = 8'd0;
    e.elems = '0;
    e.sat   = 1'b0;
    if (mx != 0) begin
      p = $clog2(mx + 1) - 1;
      s = p - 8 + 127;
      if (s < 0) s = 0;
      if (s > 254) s = 254;
      e.scale = 8'(s);
      for (int i = 0; i < BS; i++) begin
        v = real'(int'($signed(stim[i]))) * (2.0 ** real'(6 - p));
        r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
        q = int'(r);
        if (q > 127) begin q = 127; e.sat = 1'b1; end
        if (q < -127) begin q = -127; e.sat = 1'b1; end
        e.elems[i*8 +: 8] = 8'(q);
      end
    end
    sb.push_back(e);
  endtask

  task automatic send_samples(input int n, input bit push);
    int guard;
    if (push) push_expected();
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_data  = stim[i];
      guard   = 0;
      @(negedge clk);
      while (!o_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!o_ready) begin
        total_cnt++;
        $display("FAIL send_ready_timeout sample=%0d o_ready=%0b required=1", i, o_ready);
        i_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic recv_block(input string name);
    exp_t e;
    int   guard;
    i_ready = 1'b1;
    guard   = 0;
    @(negedge clk);
    while (!o_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++;
    if (!o_valid) begin
      $display("FAIL %s_valid_timeout o_valid=%0b required=1", name, o_valid);
      if (sb.size() > 0) void'(sb.pop_front());
      i_ready = 1'b0;
      return;
    end
    pass_cnt++;
    e = sb.pop_front();
    total_cnt++;
    if (o_scale !== e.scale)
      $display("FAIL %s_scale got=%0d required=%0d", name, o_scale, e.scale);
    else pass_cnt++;
    total_cnt++;
    if (o_elems !== e.elems)
      $display("FAIL %s_elems got=%h required=%h", name, o_elems, e.elems);
    else pass_cnt++;
    total_cnt++;
    if (o_saturated !== e.sat)
      $display("FAIL %s_sat got=%0b required=%0b", name, o_saturated, e.sat);
    else pass_cnt++;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_saturated !== 1'b0)
      $display("FAIL %s_after_xfer valid=%0b ready=%0b sat=%0b required=0/1/0",
               name, o_valid, o_ready, o_saturated);
    else pass_cnt++;
    $display("block %s scale=%0d sat=%0b", name, e.scale, e.sat);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    #1;
    i_rst_n = 1'b0;
    #2;
    total_cnt++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_scale !== 8'd0 ||
        o_elems !== '0 || o_saturated !== 1'b0)
      $display("FAIL reset_state ready=%0b valid=%0b scale=%0d sat=%0b elems_nz=%0b required=1/0/0/0/0",
               o_ready, o_valid, o_scale, o_saturated, |o_elems);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL reset_release ready=%0b valid=%0b required=1/0", o_ready, o_valid);
    else pass_cnt++;
  endtask

  task automatic test_unity();
    for (int i = 0; i < BS; i++) stim[i] = 16'h0100;
    send_samples(BS, 1'b1);
    recv_block("unity");
  endtask

  task automatic test_most_negative();
    stim[0] = 16'h8000;
    for (int i = 1; i < BS; i++) stim[i] = 16'h0001;
    send_samples(BS, 1'b1);
    recv_block("most_negative");
  endtask

  task automatic test_round_saturate();
    for (int i = 0; i < BS; i++) stim[i] = 16'h0000;
    stim[0] = 16'd255;
    stim[1] = 16'd3;
    stim[2] = 16'hFFFD;
    send_samples(BS, 1'b1);
    recv_block("round_saturate");
  endtask

  task automatic test_zero_then_tiny();
    for (int i = 0; i < BS; i++) stim[i] = 16'h0000;
    send_samples(BS, 1'b1);
    recv_block("all_zero");
    for (int i = 0; i < BS; i++) stim[i] = 16'h0001;
    send_samples(BS, 1'b1);
    recv_block("tiny");
  endtask

  task automatic test_hold_backpressure();
    int guard;
    for (int i = 0; i < BS; i++) stim[i] = 16'(i * 37 - 500);
    send_samples(BS, 1'b1);
    i_ready = 1'b0;
    guard   = 0;
    @(negedge clk);
    while (!o_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    i_valid = 1'b1;
    i_data  = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      total_cnt++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || sb.size() == 0 ||
          o_scale !== sb[0].scale || o_elems !== sb[0].elems || o_saturated !== sb[0].sat)
        $display("FAIL hold_cycle%0d valid=%0b ready=%0b scale=%0d required=1/0/%0d",
                 c, o_valid, o_ready, o_scale, (sb.size() > 0) ? sb[0].scale : 8'd0);
      else pass_cnt++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    recv_block("hold");
    for (int i = 0; i < BS; i++) stim[i] = 16'(i - 16);
    send_samples(BS, 1'b1);
    recv_block("after_hold");
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] t;
    int                 sh;
    for (int b = 0; b < 4; b++) begin
      sh = (b * 5) % 16;
      for (int i = 0; i < BS; i++) begin
        t       = 16'($urandom);
        stim[i] = 16'(t >>> sh);
      end
      send_samples(BS, 1'b1);
      recv_block($sformatf("random%0d", b));
    end
  endtask

  task automatic test_reset_mid_block();
    for (int i = 0; i < BS; i++) stim[i] = 16'h7FFF;
    send_samples(17, 1'b0);
    i_rst_n = 1'b0;
    #2;
    total_cnt++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_scale !== 8'd0 || o_saturated !== 1'b0)
      $display("FAIL midreset_state ready=%0b valid=%0b scale=%0d sat=%0b required=1/0/0/0",
               o_ready, o_valid, o_scale, o_saturated);
    else pass_cnt++;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < BS; i++) stim[i] = 16'h0200;
    send_samples(BS, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk);
      #1;
      if (c == 31) begin
        total_cnt++;
        if (o_valid !== 1'b0) $display("FAIL latency_early o_valid=%0b required=0", o_valid);
        else pass_cnt++;
      end
      if (c == 32) begin
        total_cnt++;
        if (o_valid !== 1'b1) $display("FAIL latency_on_time o_valid=%0b required=1", o_valid);
        else pass_cnt++;
      end
    end
    recv_block("post_reset");
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    test_reset();
    test_unity();
    test_most_negative();
    test_round_saturate();
    test_zero_then_tiny();
    test_hold_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
